multicycle_alu: RTL and testbench
=================================

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter DBITS, default 32; data width; SHALL be a power of two, at least 8.
REQ-002 Parameter OPCODE_BIT_WIDTH, default 4; opcode width; SHALL be 4 (other values unsupported).
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port aluOp, input, OPCODE_BIT_WIDTH: operation select, sampled on accept.
REQ-006 Ports inA, inB, input, DBITS: operands, sampled on accept.
REQ-007 Port in_valid, input, 1: request present.
REQ-008 Port in_ready, output, 1: block can accept; accept = in_valid && in_ready at a rising edge.
REQ-009 Port outAlu, output, DBITS: registered result.
REQ-010 Port out_zero, output, 1: registered flag, outAlu == 0.
REQ-011 Port out_err, output, 1: registered flag, illegal opcode.
REQ-012 Port out_valid, output, 1: result present; handoff = out_valid && out_ready at a rising edge.
REQ-013 Port out_ready, input, 1: consumer can take the result.

Function
REQ-014 Encoding: 0000 ADD, 0001 SUB, 0100 AND, 0101 OR, 0110 XOR, 1100 NAND, 1101 NOR, 1110 NXOR, 1000 MUL, 1001 SLL, 1010 SRL, 1011 SRA; all other codes are illegal.
REQ-015 Arithmetic SHALL be modulo 2^DBITS; SUB = inA + ~inB + 1; MUL = low DBITS bits of the unsigned product.
REQ-016 Shift amount = inB[log2(DBITS)-1:0]; SLL/SRL zero-fill; SRA replicates inA[DBITS-1].
REQ-017 FSM states: IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-018 IDLE: on accept, latch aluOp, inA and inB; later input changes SHALL have no effect on the operation.
REQ-019 Illegal op or single-cycle op (ADD..NXOR) -> DONE at edge T+1; out_valid high from T+1 (T = accept edge).
REQ-020 Illegal op: outAlu = 0, out_err = 1, out_zero = 1.
REQ-021 MUL: shift-add, one multiplier bit per cycle; BUSY for DBITS cycles; out_valid from T+DBITS+1.
REQ-022 SLL/SRL/SRA: one bit position per cycle; BUSY for shamt cycles; out_valid from T+shamt+1; shamt = 0 -> T+1 and outAlu = inA.
REQ-023 BUSY -> DONE when the iteration count is exhausted; outAlu, out_zero and out_err SHALL be written on the same edge.
REQ-024 DONE: out_valid = 1; outAlu and flags held stable until handoff.
REQ-025 DONE with out_ready = 0: remain in DONE indefinitely, no output change.
REQ-026 Handoff -> IDLE on the next edge; out_valid low in IDLE; outAlu and flags keep their last values.
REQ-027 No new accept in the handoff cycle; back-to-back throughput is at most one op per 2 cycles for single-cycle ops.
REQ-028 out_err SHALL be 0 for every legal opcode.

Reset
REQ-029 reset = 1 at an edge -> next state IDLE; outAlu = 0; out_zero = 1; out_err = 0; out_valid = 0; in_ready = 1; iteration counter = 0.
REQ-030 Reset SHALL take priority over accept, iteration and handoff; an in-flight BUSY/DONE op is discarded and not reported.
REQ-031 in_valid asserted during reset SHALL NOT be accepted.

Verification
REQ-032 ADD: inA = 5, inB = 3, accept at T -> out_valid at T+1, outAlu = 8, out_zero = 0; SUB: 3 - 5 -> 0xFFFFFFFE.
REQ-033 MUL: DBITS = 32, 7 x 6 -> in_ready low T+1..T+33, out_valid at T+33, outAlu = 42; 0xFFFFFFFF x 2 -> 0xFFFFFFFE.
REQ-034 SRA: 0x80000000 by 4 -> out_valid at T+5, outAlu = 0xF8000000; SLL by 0 -> T+1, outAlu = inA.
REQ-035 Backpressure: out_ready low for 10 cycles in DONE -> outAlu and out_valid stable; inputs toggled meanwhile are ignored; out_ready high -> IDLE next cycle.
REQ-036 Reset at T+10 of MUL -> IDLE at T+11, outAlu = 0, out_valid = 0; a subsequent ADD 1 + 1 = 2 completes correctly.
REQ-037 Opcode 0011 -> out_valid at T+1, out_err = 1, outAlu = 0, out_zero = 1; XOR of equal operands -> out_zero = 1, out_err = 0.

Source files
------------

// File: rtl/multicycle_alu.sv
// -----------------------------------------------------------------------------
// multicycle_alu
//   Multi-cycle ALU with a valid/ready request port and a valid/ready result
//   port. Logic and add/sub ops finish in one compute cycle. MUL is an
//   iterative shift-add that takes one multiplier bit per cycle. Shifts move
//   one bit position per cycle.
//
// Handshake:
//   A request is accepted on a rising edge where in_valid && in_ready.
//   A result is handed off on a rising edge where out_valid && out_ready.
//   in_ready is high only in IDLE. out_valid is high only in DONE. The
//   producer may hold or drop in_valid freely. The result and its flags stay
//   stable while out_valid is high and out_ready is low.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   aluOp, inA, inB      opcode and operands, latched on accept
//   in_valid, in_ready   request handshake
//   outAlu               registered result
//   out_zero, out_err    registered flags (result == 0, illegal opcode)
//   out_valid, out_ready result handshake
//   o_dbg_state          current FSM state (0 IDLE, 1 BUSY, 2 DONE)
// -----------------------------------------------------------------------------
module multicycle_alu #(
  parameter int DBITS            = 32,
  parameter int OPCODE_BIT_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [OPCODE_BIT_WIDTH-1:0] aluOp,
  input  logic [DBITS-1:0]            inA,
  input  logic [DBITS-1:0]            inB,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [DBITS-1:0]            outAlu,
  output logic                        out_zero,
  output logic                        out_err,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [1:0]                  o_dbg_state
);

  localparam int SW = $clog2(DBITS);
  // One extra bit so the counter can hold DBITS itself for MUL.
  localparam int CW = SW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NAND = 4'b1100;
  localparam logic [3:0] OP_NOR  = 4'b1101;
  localparam logic [3:0] OP_NXOR = 4'b1110;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;

  logic [1:0]                  r_state;
  logic [OPCODE_BIT_WIDTH-1:0] r_op;
  logic [DBITS-1:0]            r_a;
  logic [DBITS-1:0]            r_b;
  logic [DBITS-1:0]            r_acc;
  logic [CW-1:0]               r_cnt;
  logic [DBITS-1:0]            r_out_alu;
  logic                        r_out_zero;
  logic                        r_out_err;

  logic                        w_accept;
  logic                        w_handoff;
  logic [CW-1:0]               w_load_cnt;
  logic [DBITS-1:0]            w_result;
  logic                        w_err;

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign o_dbg_state = r_state;
  assign outAlu      = r_out_alu;
  assign out_zero    = r_out_zero;
  assign out_err     = r_out_err;

  assign w_accept  = in_valid && in_ready;
  assign w_handoff = out_valid && out_ready;

  // Number of iteration cycles that precede the final write cycle.
  always_comb begin
    w_load_cnt = '0;
    case (aluOp)
      OP_MUL:                 w_load_cnt = CW'(DBITS);
      OP_SLL, OP_SRL, OP_SRA: w_load_cnt = {1'b0, inB[SW-1:0]};
      default:                w_load_cnt = '0;
    endcase
  end

  // Final value written into the output registers once the iteration count
  // is exhausted. MUL and the shifts have already done their work in r_acc
  // and r_a. Single-cycle ops are evaluated here from the latched operands.
  always_comb begin
    w_result = '0;
    w_err    = 1'b0;
    case (r_op)
      OP_ADD:                 w_result = r_a + r_b;
      OP_SUB:                 w_result = r_a + ~r_b + DBITS'(1);
      OP_AND:                 w_result = r_a & r_b;
      OP_OR:                  w_result = r_a | r_b;
      OP_XOR:                 w_result = r_a ^ r_b;
      OP_NAND:                w_result = ~(r_a & r_b);
      OP_NOR:                 w_result = ~(r_a | r_b);
      OP_NXOR:                w_result = ~(r_a ^ r_b);
      OP_MUL:                 w_result = r_acc;
      OP_SLL, OP_SRL, OP_SRA: w_result = r_a;
      default: begin
        w_result = '0;
        w_err    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_out_alu  <= '0;
      r_out_zero <= 1'b1;
      r_out_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= aluOp;
            r_a     <= inA;
            r_b     <= inB;
            r_acc   <= '0;
            r_cnt   <= w_load_cnt;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt == '0) begin
            r_out_alu  <= w_result;
            r_out_zero <= ~|w_result;
            r_out_err  <= w_err;
            r_state    <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
            case (r_op)
              OP_MUL: begin
                // Shift-add: r_a carries the multiplicand shifted into
                // place, r_b supplies the next multiplier bit at bit 0.
                if (r_b[0]) r_acc <= r_acc + r_a;
                r_a <= r_a << 1;
                r_b <= r_b >> 1;
              end
              OP_SLL:  r_a <= r_a << 1;
              OP_SRL:  r_a <= r_a >> 1;
              OP_SRA:  r_a <= {r_a[DBITS-1], r_a[DBITS-1:1]};
              default: r_a <= r_a;
            endcase
          end
        end
        S_DONE: begin
          if (w_handoff) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
module tb_multicycle_alu;

  localparam int DBITS = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       aluOp;
  logic [DBITS-1:0] inA;
  logic [DBITS-1:0] inB;
  logic             in_valid;
  logic             in_ready;
  logic [DBITS-1:0] outAlu;
  logic             out_zero;
  logic             out_err;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       o_dbg_state;

  multicycle_alu #(.DBITS(DBITS), .OPCODE_BIT_WIDTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .aluOp       (aluOp),
    .inA         (inA),
    .inB         (inB),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .outAlu      (outAlu),
    .out_zero    (out_zero),
    .out_err     (out_err),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [33:0] exp_q[$];   // {err, zero, result}
  int          lat_q[$];   // cycle index at which out_valid must first be seen
  int          chk  = 0;
  int          errs = 0;
  bit          rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [33:0] model(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0]        r;
    logic signed [31:0] sa;
    logic [63:0]        p;
    logic               e;
    int                 sh;
    sh = int'(b[4:0]);
    sa = a;
    e  = 1'b0;
    p  = {32'b0, a} * {32'b0, b};
    case (op)
      4'h0: r = a + b;
      4'h1: r = a - b;
      4'h4: r = a & b;
      4'h5: r = a | b;
      4'h6: r = a ^ b;
      4'hC: r = ~(a & b);
      4'hD: r = ~(a | b);
      4'hE: r = ~(a ^ b);
      4'h8: r = p[31:0];
      4'h9: r = a << sh;
      4'hA: r = a >> sh;
      4'hB: r = sa >>> sh;
      default: begin r = 32'h0; e = 1'b1; end
    endcase
    return {e, (r == 32'h0), r};
  endfunction

  function automatic int latency(input logic [3:0] op, input logic [31:0] b);
    case (op)
      4'h8:             return DBITS;
      4'h9, 4'hA, 4'hB: return int'(b[4:0]);
      default:          return 0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a rising edge. Returns just after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int guard;
    guard    = 0;
    aluOp    = op;
    inA      = a;
    inB      = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("accept_wait", 64'(in_ready), 64'(1));
    exp_q.push_back(model(op, a, b));
    lat_q.push_back(cyc + 2 + latency(op, b));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Scramble inputs: the operation must use only the latched values.
    aluOp = 4'($urandom);
    inA   = $urandom;
    inB   = $urandom;
  endtask

  task automatic wait_drain(input int budget);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < budget) begin
      @(posedge clk);
      g++;
    end
    check("drain", 64'(exp_q.size()), 64'(0));
    #1;
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic        prev_v;
    logic [33:0] e_res;
    int          e_lat;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (out_valid && !prev_v) begin
          if (lat_q.size() == 0) check("unexpected_valid", 64'(1), 64'(0));
          else begin
            e_lat = lat_q.pop_front();
            check("latency", 64'(cyc), 64'(e_lat));
          end
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check("unexpected_result", 64'(1), 64'(0));
          else begin
            e_res = exp_q.pop_front();
            check("result", 64'({out_err, out_zero, outAlu}), 64'(e_res));
          end
        end
      end
      prev_v = out_valid;
    end
  end

  // Random consumer backpressure, enabled for the random phase only.
  initial begin : ready_gen
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete (checks %0d)", chk);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    logic [31:0] hold;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    reset     = 1'b1;
    in_valid  = 1'b1;   // must be ignored while reset is high
    aluOp     = 4'h0;
    inA       = 32'd5;
    inB       = 32'd3;
    out_ready = 1'b1;

    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_in_ready", 64'(in_ready), 64'(1));
      check("reset_out_valid", 64'(out_valid), 64'(0));
      check("reset_state", 64'(o_dbg_state), 64'(0));
    end
    check("reset_outAlu", 64'(outAlu), 64'(0));
    check("reset_zero", 64'(out_zero), 64'(1));
    check("reset_err", 64'(out_err), 64'(0));
    in_valid = 1'b0;
    reset    = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases
    issue(4'h0, 32'd5, 32'd3);
    issue(4'h1, 32'd3, 32'd5);
    issue(4'h8, 32'd7, 32'd6);
    @(negedge clk);
    check("mul_busy_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    issue(4'h8, 32'hFFFF_FFFF, 32'd2);
    issue(4'hB, 32'h8000_0000, 32'd4);
    issue(4'h9, 32'h1234_5678, 32'd0);
    issue(4'hA, 32'hF000_000F, 32'd31);
    issue(4'h3, 32'd9, 32'd9);
    issue(4'h6, 32'hA5A5_1234, 32'hA5A5_1234);
    wait_drain(200);

    // Backpressure: result held for 10 cycles while inputs wiggle
    out_ready = 1'b0;
    issue(4'h5, 32'h0F0F_0000, 32'h0000_00F0);
    for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
    check("bp_valid_seen", 64'(out_valid), 64'(1));
    hold = 32'h0F0F_00F0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      aluOp    = 4'($urandom);
      inA      = $urandom;
      inB      = $urandom;
      in_valid = 1'b1;
      @(negedge clk);
      check("bp_outAlu_stable", 64'(outAlu), 64'(hold));
      check("bp_valid_stable", 64'(out_valid), 64'(1));
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);   // handoff edge
    #1;
    @(negedge clk);
    check("bp_idle_ready", 64'(in_ready), 64'(1));
    check("bp_idle_valid", 64'(out_valid), 64'(0));
    check("bp_idle_keep", 64'(outAlu), 64'(hold));
    check("bp_drained", 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #1;

    // Reset in the middle of a MUL
    issue(4'h0, 32'd5, 32'd3);
    wait_drain(200);
    issue(4'h8, 32'h0000_1234, 32'h0000_0055);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    lat_q.delete();
    @(negedge clk);
    check("midreset_valid", 64'(out_valid), 64'(0));
    check("midreset_outAlu", 64'(outAlu), 64'(0));
    check("midreset_in_ready", 64'(in_ready), 64'(1));
    check("midreset_zero", 64'(out_zero), 64'(1));
    @(posedge clk);
    #1;
    issue(4'h0, 32'd1, 32'd1);
    wait_drain(200);

    // Randomized phase with random consumer backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      issue(op, a, b);
    end
    wait_drain(4000);
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", chk, errs);
    $finish;
  end

endmodule
